// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (D/E, E/M, M/W) with stall, flush, Tnew countdown and forwarding-ready flag.
// Latency: one cycle from any input to the matching output; outputs are driven only by flops.
// Backpressure: en=0 holds the slot (Tnew still counts down); flush overrides en and inserts a bubble.
module pipe_stage_reg #(
    parameter int DATA_W           = 32,
    parameter int N_WORDS          = 3,
    parameter int CTRL_W           = 8,
    parameter int TNEW_W           = 2,
    parameter int AREG_W           = 5,
    parameter bit KEEP_PC_ON_FLUSH = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      valid_i,
    input  logic                      regwrite_i,
    input  logic [CTRL_W-1:0]         ctrl_i,
    input  logic [N_WORDS*DATA_W-1:0] data_i,
    input  logic [31:0]               pc_i,
    input  logic [AREG_W-1:0]         awrite_i,
    input  logic [TNEW_W-1:0]         tnew_i,
    output logic                      valid_o,
    output logic                      regwrite_o,
    output logic [CTRL_W-1:0]         ctrl_o,
    output logic [N_WORDS*DATA_W-1:0] data_o,
    output logic [31:0]               pc_o,
    output logic [AREG_W-1:0]         awrite_o,
    output logic [TNEW_W-1:0]         tnew_o,
    output logic                      fwd_rdy_o
);

    // Everything the stage holds for one instruction slot.
    typedef struct packed {
        logic                      valid;
        logic                      regwrite;
        logic [CTRL_W-1:0]         ctrl;
        logic [N_WORDS*DATA_W-1:0] data;
        logic [31:0]               pc;
        logic [AREG_W-1:0]         awrite;
        logic [TNEW_W-1:0]         tnew;
        logic                      fwd_rdy;
    } slot_t;

    slot_t cur_slot;
    slot_t nxt_slot;

    // Tnew counts down by one per cycle and sticks at zero; it never wraps.
    function automatic logic [TNEW_W-1:0] dec_sat(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    // Next slot contents: flush beats stall beats load; fwd_rdy is derived from the chosen result.
    always_comb begin
        nxt_slot      = cur_slot;
        nxt_slot.tnew = dec_sat(cur_slot.tnew);
        if (flush) begin
            nxt_slot = '0;
            // The bubble carries the PC of the discarded instruction so EPC can still be taken from it.
            if (KEEP_PC_ON_FLUSH) begin
                nxt_slot.pc = pc_i;
            end
        end else if (en) begin
            nxt_slot.valid    = valid_i;
            nxt_slot.regwrite = regwrite_i;
            nxt_slot.ctrl     = ctrl_i;
            nxt_slot.data     = data_i;
            nxt_slot.pc       = pc_i;
            nxt_slot.awrite   = awrite_i;
            nxt_slot.tnew     = dec_sat(tnew_i);
        end
        // $0 is never a real producer, so it never reports ready.
        nxt_slot.fwd_rdy = nxt_slot.valid & nxt_slot.regwrite & (|nxt_slot.awrite) &
                           (nxt_slot.tnew == '0);
    end

    // Slot register with synchronous active-low clear that dominates flush and en.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_slot <= '0;
        end else begin
            cur_slot <= nxt_slot;
        end
    end

    assign valid_o    = cur_slot.valid;
    assign regwrite_o = cur_slot.regwrite;
    assign ctrl_o     = cur_slot.ctrl;
    assign data_o     = cur_slot.data;
    assign pc_o       = cur_slot.pc;
    assign awrite_o   = cur_slot.awrite;
    assign tnew_o     = cur_slot.tnew;
    assign fwd_rdy_o  = cur_slot.fwd_rdy;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations driven from shared control, checked against a behavioural model.
// Latency: expectations are applied one edge after the inputs that produced them.
// Backpressure: stall cycles are exercised both directed and randomly.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, flush, valid_i, regwrite_i;
    logic [7:0]  ctrl_i;
    logic [31:0] pc_i;
    logic [4:0]  awrite_i;
    logic [95:0] data_a;
    logic [63:0] data_b;
    logic [15:0] data_c;
    logic [1:0]  tn_a;
    logic [2:0]  tn3;

    // DUT A: defaults (DATA_W=32, N_WORDS=3, TNEW_W=2, keep PC)
    logic        valid_a, rw_a, fwd_a;
    logic [7:0]  ctrl_a;
    logic [95:0] dout_a;
    logic [31:0] pc_a;
    logic [4:0]  aw_a;
    logic [1:0]  tnew_a;
    // DUT B: N_WORDS=4, DATA_W=16, TNEW_W=3, zero PC on flush
    logic        valid_b, rw_b, fwd_b;
    logic [7:0]  ctrl_b;
    logic [63:0] dout_b;
    logic [31:0] pc_b;
    logic [4:0]  aw_b;
    logic [2:0]  tnew_b;
    // DUT C: N_WORDS=1, DATA_W=16, TNEW_W=3, keep PC
    logic        valid_c, rw_c, fwd_c;
    logic [7:0]  ctrl_c;
    logic [15:0] dout_c;
    logic [31:0] pc_c;
    logic [4:0]  aw_c;
    logic [2:0]  tnew_c;

    pipe_stage_reg u_a (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i),
        .regwrite_i(regwrite_i), .ctrl_i(ctrl_i), .data_i(data_a), .pc_i(pc_i),
        .awrite_i(awrite_i), .tnew_i(tn_a), .valid_o(valid_a), .regwrite_o(rw_a),
        .ctrl_o(ctrl_a), .data_o(dout_a), .pc_o(pc_a), .awrite_o(aw_a),
        .tnew_o(tnew_a), .fwd_rdy_o(fwd_a)
    );

    pipe_stage_reg #(.DATA_W(16), .N_WORDS(4), .TNEW_W(3), .KEEP_PC_ON_FLUSH(1'b0)) u_b (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i),
        .regwrite_i(regwrite_i), .ctrl_i(ctrl_i), .data_i(data_b), .pc_i(pc_i),
        .awrite_i(awrite_i), .tnew_i(tn3), .valid_o(valid_b), .regwrite_o(rw_b),
        .ctrl_o(ctrl_b), .data_o(dout_b), .pc_o(pc_b), .awrite_o(aw_b),
        .tnew_o(tnew_b), .fwd_rdy_o(fwd_b)
    );

    pipe_stage_reg #(.DATA_W(16), .N_WORDS(1), .TNEW_W(3), .KEEP_PC_ON_FLUSH(1'b1)) u_c (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i),
        .regwrite_i(regwrite_i), .ctrl_i(ctrl_i), .data_i(data_c), .pc_i(pc_i),
        .awrite_i(awrite_i), .tnew_i(tn3), .valid_o(valid_c), .regwrite_o(rw_c),
        .ctrl_o(ctrl_c), .data_o(dout_c), .pc_o(pc_c), .awrite_o(aw_c),
        .tnew_o(tnew_c), .fwd_rdy_o(fwd_c)
    );

    int passed = 0;
    int total  = 0;

    // Behavioural model: one record per DUT, Tnew kept as a plain integer.
    logic        m_valid [3];
    logic        m_rw    [3];
    logic [7:0]  m_ctrl  [3];
    logic [95:0] m_data  [3];
    logic [31:0] m_pc    [3];
    logic [4:0]  m_aw    [3];
    int          m_tn    [3];
    logic        m_fwd   [3];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            int          tin;
            logic [95:0] din;
            tin = (i == 0) ? int'(tn_a) : int'(tn3);
            din = (i == 0) ? data_a : (i == 1) ? {32'h0, data_b} : {80'h0, data_c};
            if (!reset) begin
                m_valid[i] = 1'b0; m_rw[i] = 1'b0; m_ctrl[i] = '0; m_data[i] = '0;
                m_pc[i] = '0; m_aw[i] = '0; m_tn[i] = 0;
            end else if (flush) begin
                m_valid[i] = 1'b0; m_rw[i] = 1'b0; m_ctrl[i] = '0; m_data[i] = '0;
                m_aw[i] = '0; m_tn[i] = 0;
                m_pc[i] = (i == 1) ? 32'h0 : pc_i;
            end else if (!en) begin
                m_tn[i] = (m_tn[i] > 0) ? m_tn[i] - 1 : 0;
            end else begin
                m_valid[i] = valid_i; m_rw[i] = regwrite_i; m_ctrl[i] = ctrl_i;
                m_data[i] = din; m_pc[i] = pc_i; m_aw[i] = awrite_i;
                m_tn[i] = (tin > 0) ? tin - 1 : 0;
            end
            m_fwd[i] = m_valid[i] && m_rw[i] && (m_aw[i] != 0) && (m_tn[i] == 0) && reset;
        end
    endtask

    task automatic check_all();
        check("a_valid", valid_a, m_valid[0]); check("a_rw", rw_a, m_rw[0]);
        check("a_ctrl", ctrl_a, m_ctrl[0]);    check("a_data", dout_a, m_data[0]);
        check("a_pc", pc_a, m_pc[0]);          check("a_aw", aw_a, m_aw[0]);
        check("a_tnew", tnew_a, m_tn[0]);      check("a_fwd", fwd_a, m_fwd[0]);
        check("b_valid", valid_b, m_valid[1]); check("b_rw", rw_b, m_rw[1]);
        check("b_ctrl", ctrl_b, m_ctrl[1]);    check("b_data", dout_b, m_data[1]);
        check("b_pc", pc_b, m_pc[1]);          check("b_aw", aw_b, m_aw[1]);
        check("b_tnew", tnew_b, m_tn[1]);      check("b_fwd", fwd_b, m_fwd[1]);
        check("c_valid", valid_c, m_valid[2]); check("c_rw", rw_c, m_rw[2]);
        check("c_ctrl", ctrl_c, m_ctrl[2]);    check("c_data", dout_c, m_data[2]);
        check("c_pc", pc_c, m_pc[2]);          check("c_aw", aw_c, m_aw[2]);
        check("c_tnew", tnew_c, m_tn[2]);      check("c_fwd", fwd_c, m_fwd[2]);
    endtask

    // One clock: model follows the edge, outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        // Reset with every input driven high
        reset = 1'b0; en = 1'b1; flush = 1'b1; valid_i = 1'b1; regwrite_i = 1'b1;
        ctrl_i = '1; pc_i = '1; awrite_i = '1; data_a = '1; data_b = '1; data_c = '1;
        tn_a = '1; tn3 = '1;
        step();
        step();
        check("rst_pc", pc_a, 32'h0);
        check("rst_fwd", fwd_a, 1'b0);
        check("rst_data", dout_a, 96'h0);

        // Release: next edge loads the all-ones inputs
        reset = 1'b1; flush = 1'b0;
        step();
        check("rel_valid", valid_a, 1'b1);
        check("rel_tnew", tnew_a, 2'd2);

        // Load and countdown
        valid_i = 1'b1; regwrite_i = 1'b1; awrite_i = 5'd5; tn_a = 2'd2; tn3 = 3'd2;
        ctrl_i = 8'h5a; pc_i = 32'h3004; data_a = {64'h0, 32'h12345678};
        data_b = 64'h0; data_c = 16'h0;
        step();
        check("ld_tnew", tnew_a, 2'd1);
        check("ld_fwd", fwd_a, 1'b0);
        check("ld_word0", dout_a[31:0], 32'h12345678);
        check("ld_pc", pc_a, 32'h3004);
        tn_a = 2'd1;
        step();
        check("ld1_tnew", tnew_a, 2'd0);
        check("ld1_fwd", fwd_a, 1'b1);
        tn_a = 2'd0;
        step();
        check("ld0_tnew", tnew_a, 2'd0);
        check("ld0_fwd", fwd_a, 1'b1);

        // Stall countdown, with parameter sweep packing on B and C
        tn_a = 2'd3; tn3 = 3'd7;
        data_b = 64'h4444_3333_2222_1111; data_c = 16'hbeef;
        step();
        check("st_load_a", tnew_a, 2'd2);
        check("st_load_b", tnew_b, 3'd6);
        en = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            int exp_a;
            int exp_b;
            // Garbage on inputs must not leak through while stalled
            pc_i = $urandom; data_a = {$urandom, $urandom, $urandom}; awrite_i = 5'($urandom);
            data_b = {$urandom, $urandom}; data_c = 16'($urandom);
            step();
            exp_a = (2 - k > 0) ? 2 - k : 0;
            exp_b = (6 - k > 0) ? 6 - k : 0;
            check("st_tnew_a", tnew_a, exp_a);
            check("st_fwd_a", fwd_a, exp_a == 0);
            check("st_tnew_b", tnew_b, exp_b);
            check("st_word2_b", dout_b[32 +: 16], 16'h3333);
            check("st_word0_c", dout_c, 16'hbeef);
        end

        // Flush beats en
        en = 1'b1; flush = 1'b1; valid_i = 1'b1; pc_i = 32'h3010;
        step();
        check("fl_valid", valid_a, 1'b0);
        check("fl_pc_keep", pc_a, 32'h3010);
        check("fl_pc_zero", pc_b, 32'h0);
        check("fl_aw", aw_a, 5'd0);

        // $0 destination and invalid slot never forward
        flush = 1'b0; valid_i = 1'b1; regwrite_i = 1'b1; awrite_i = 5'd0; tn_a = 2'd0; tn3 = 3'd0;
        step();
        check("r0_fwd", fwd_a, 1'b0);
        valid_i = 1'b0; awrite_i = 5'd7;
        step();
        check("inv_fwd", fwd_a, 1'b0);
        check("inv_rw", rw_a, 1'b1);

        // Reset during a stall, then released while still stalled
        en = 1'b0; reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("rst_stall_aw", aw_a, 5'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 19) != 0);
            flush      = ($urandom_range(0, 7) == 0);
            en         = ($urandom_range(0, 3) != 0);
            valid_i    = 1'($urandom);
            regwrite_i = 1'($urandom);
            ctrl_i     = 8'($urandom);
            pc_i       = $urandom;
            awrite_i   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            data_a     = {$urandom, $urandom, $urandom};
            data_b     = {$urandom, $urandom};
            data_c     = 16'($urandom);
            tn_a       = 2'($urandom);
            tn3        = 3'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised inter-stage pipeline register for the five-stage CPU; replaces the per-stage D/E, E/M and M/W registers with one block.
- Carries a valid bit, a control bundle, N data words, PC, the write-register address and a Tnew counter.
- Adds stall (hold), flush (bubble insertion), a saturating Tnew countdown that also runs while stalled, and a registered forwarding-ready flag for the hazard unit.

Parameters:
- DATA_W, 32, width of each data word
- N_WORDS, 3, number of data words carried (e.g. ALUout, RD, RT value)
- CTRL_W, 8, width of the opaque control bundle
- TNEW_W, 2, width of the Tnew counter
- AREG_W, 5, width of the write-register address
- KEEP_PC_ON_FLUSH, 1, 1: a bubble keeps the incoming PC (needed for EPC); 0: a bubble zeroes PC

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous active-low reset
- en  in  1  1: load next stage inputs; 0: stall, hold contents
- flush  in  1  insert a bubble this cycle
- valid_i  in  1  incoming slot holds a real instruction
- regwrite_i  in  1  incoming instruction writes the GRF
- ctrl_i  in  CTRL_W  control bundle
- data_i  in  N_WORDS*DATA_W  packed data words, word k at bits [k*DATA_W +: DATA_W]
- pc_i  in  32  instruction PC
- awrite_i  in  AREG_W  destination register
- tnew_i  in  TNEW_W  cycles until the result is available, as seen at this stage's input
- valid_o  out  1  registered valid
- regwrite_o  out  1  registered regwrite
- ctrl_o  out  CTRL_W  registered control bundle
- data_o  out  N_WORDS*DATA_W  registered data words
- pc_o  out  32  registered PC
- awrite_o  out  AREG_W  registered destination
- tnew_o  out  TNEW_W  registered Tnew
- fwd_rdy_o  out  1  registered; 1 when this stage can forward a finished result

Behaviour:
- All updates happen on the rising clk edge. Priority order: reset low > flush > en=0 (stall) > load.
- Reset (reset==0 at the edge): every output goes to 0, including fwd_rdy_o and pc_o. Reset dominates flush and en.
- Flush (reset==1, flush==1, en ignored):
  - valid_o, regwrite_o, ctrl_o, data_o, awrite_o, tnew_o and fwd_rdy_o go to 0.
  - pc_o takes pc_i when KEEP_PC_ON_FLUSH=1, else 0.
- Stall (reset==1, flush==0, en==0):
  - All fields hold, except tnew_o, which becomes tnew_o-1 saturating at 0.
  - fwd_rdy_o is recomputed from the held fields and the new tnew_o.
- Load (reset==1, flush==0, en==1):
  - All fields take their inputs.
  - tnew_o becomes tnew_i-1 saturating at 0, so tnew_i==0 gives 0. No wrap-around for any TNEW_W.
- fwd_rdy_o next value = next valid & next regwrite & (next awrite != 0) & (next tnew == 0). Register 0 never reports ready.
- Latency is one cycle input to output. There is no combinational path from any input to any output.
- A bubble (valid_i==0) loaded with en=1 passes through unchanged: regwrite_i is still registered as given. The hazard unit qualifies with valid_o.
- Simultaneous flush and en=1: flush wins, and the incoming instruction is discarded.
- Reset deasserted mid-stall: the register stays at 0 until the first non-reset edge applies the normal rules.
- All widths follow the parameters. N_WORDS=1 must be legal.

Test Plan:
- Reset: reset=0 for 2 cycles with all inputs at 0xFFFF... and en=1 -> every output 0, fwd_rdy_o=0; release -> next edge loads the inputs.
- Load and countdown: en=1, valid_i=1, regwrite_i=1, awrite_i=5, tnew_i=2, data word0=0x12345678, pc_i=0x3004.
  - Next cycle: tnew_o=1, fwd_rdy_o=0, data and PC match.
  - Reload with tnew_i=1: tnew_o=0, fwd_rdy_o=1.
  - Reload with tnew_i=0: tnew_o=0, fwd_rdy_o=1.
- Stall countdown: load tnew_i=3 with TNEW_W=2, then en=0 for 4 cycles -> tnew_o sequence 2,1,0,0, all other fields held, fwd_rdy_o rises with tnew_o==0 and stays 1.
- Flush priority: flush=1 with en=1, valid_i=1, pc_i=0x3010 -> valid_o=0, regwrite_o=0, awrite_o=0, data_o=0, pc_o=0x3010 (KEEP_PC_ON_FLUSH=1) or 0 (KEEP_PC_ON_FLUSH=0).
- $0 destination: load regwrite_i=1, awrite_i=0, tnew_i=0 -> fwd_rdy_o=0.
  - Same with valid_i=0 and awrite_i=7 -> fwd_rdy_o=0.
- Parameter sweep: N_WORDS=1 and N_WORDS=4, DATA_W=16, TNEW_W=3, tnew_i=7 followed by 8 stall cycles -> word packing correct, tnew_o goes 6 down to 0 and stays 0 with no wrap.
